key_pulse_debouncer: RTL

Conditions a raw, bouncing, active-low push-button (KEY) into a clean debounced level and single-cycle enable pulses, with optional auto-repeat while the button is held.
Runs on the board system clock (CLOCK_50) and sits directly upstream of the T-flip-flop counter stage, whose Enable input it drives.
This makes one button press advance the counter by exactly one count on a free-running clock, instead of the button itself being used as the counter clock.

---
 rtl/key_pulse_debouncer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer
//   Turns a raw, bouncing, active-low push-button into a clean debounced level
//   and single-cycle enable pulses. Auto-repeat while held is optional. The
//   pulse is meant to drive the Enable input of a counter that runs on the free
//   system clock, so that one press advances the counter by exactly one.
//
// Ports
//   Clock   in   system clock; all registers update on its rising edge
//   Reset   in   synchronous, active-high reset
//   KEY     in   raw push-button, active-low (0 = pressed), asynchronous
//   Pressed out  debounced button level, 1 = held
//   Pulse   out  one-cycle enable pulse
module key_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KEY,
  output logic Pressed,
  output logic Pulse
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_TC = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_TC = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pulse_nx;
  logic          pressed_nx;
  logic          key_p0, key_p1;
  logic          key_s;

  // Stage p0/p1: two-flop synchronizer; key_s is the active-high press level
  assign key_s = ~key_p1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_p0  <= 1'b1;
      key_p1  <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      Pulse   <= 1'b0;
      Pressed <= 1'b0;
    end else begin
      key_p0  <= KEY;
      key_p1  <= key_p0;
      state   <= state_nx;
      cnt     <= cnt_nx;
      Pulse   <= pulse_nx;
      Pressed <= pressed_nx;
    end
  end

  // Next state; the key_s exit always wins over a terminal count in the same
  // cycle, so a release never produces a pulse.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + ONE;
    pulse_nx = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = ONE;
        end else begin
          cnt_nx = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          state_nx = HELD;
          cnt_nx   = '0;
          pulse_nx = 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = ONE;
        end else if ((REPEAT_EN != 0) && (cnt == DLY_TC)) begin
          state_nx = REPEAT;
          cnt_nx   = '0;
          pulse_nx = 1'b1;
        end else if (cnt == DLY_TC) begin
          // Without auto-repeat the count parks here instead of wrapping.
          cnt_nx = cnt;
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = ONE;
        end else if (cnt == PER_TC) begin
          cnt_nx   = '0;
          pulse_nx = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          // Release bounce: back to HELD with the repeat delay restarted.
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == DEB_TC) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    pressed_nx = (state_nx == HELD) || (state_nx == REPEAT) || (state_nx == RELEASE_WAIT);
  end

endmodule
